// File: rtl/txn_seq_pkg.sv
// Shared state/status encodings and fixed timing constants for the transaction sequencer.
package txn_seq_pkg;

    typedef enum logic [2:0] {
        INIT   = 3'd0,
        WARM   = 3'd1,
        IDLE   = 3'd2,
        LAUNCH = 3'd3,
        BUSY   = 3'd4,
        FINISH = 3'd5,
        STATUS = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        DONE        = 2'b00,
        STOPPED     = 2'b01,
        ENG_ERR     = 2'b10,
        TIMEOUT_ERR = 2'b11
    } status_t;

    localparam int WARM_CYCLES = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner search starting one place above the last winner.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_idx,
    output logic                     valid
);

    localparam int PTR_W = $clog2(N_REQ);

    logic [PTR_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = PTR_W'((int'(ptr) + k) % N_REQ);
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/txn_sequencer.sv
// Shares one engine among N_REQ requesters: power-up INIT/WARM, then grant, launch,
// wait for the engine (with watchdog), and report termination and status.
module txn_sequencer
    import txn_seq_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int INIT_CYCLES = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         ack,
    input  logic                     stop_req,
    input  logic                     eng_done,
    input  logic                     eng_err,
    output logic                     rt,
    output logic                     enable,
    output logic                     start,
    output logic                     rdy,
    output logic                     endd,
    output logic                     stop,
    output logic                     er,
    output logic                     interrupt,
    output logic                     status_valid,
    output logic [1:0]               status,
    output logic [$clog2(N_REQ)-1:0] owner
);

    localparam int PTR_W   = $clog2(N_REQ);
    localparam int CNT_MAX = (INIT_CYCLES > WARM_CYCLES) ? INIT_CYCLES : WARM_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int WD_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [WD_W:0] WD_LIMIT = (WD_W + 1)'(TIMEOUT);

    localparam logic [2:0] S_INIT   = INIT;
    localparam logic [2:0] S_WARM   = WARM;
    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_LAUNCH = LAUNCH;
    localparam logic [2:0] S_BUSY   = BUSY;
    localparam logic [2:0] S_FINISH = FINISH;
    localparam logic [2:0] S_STATUS = STATUS;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WD_W-1:0]  wd_cnt;
    logic [WD_W:0]    wd_next;
    logic             wd_expire;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] owner_q;
    logic [N_REQ-1:0] grant_q;
    status_t          cause_q;
    logic             enable_q;

    logic [N_REQ-1:0] arb_grant;
    logic [PTR_W-1:0] arb_idx;
    logic             arb_valid;

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_arb (
        .req      (req),
        .ptr      (ptr),
        .grant    (arb_grant),
        .grant_idx(arb_idx),
        .valid    (arb_valid)
    );

    assign wd_next   = {1'b0, wd_cnt} + (WD_W + 1)'(1);
    assign wd_expire = (TIMEOUT != 0) && (wd_next == WD_LIMIT);

    // INIT also covers the reset period itself, so it counts INIT_CYCLES edges after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_INIT;
            cnt      <= '0;
            wd_cnt   <= '0;
            ptr      <= PTR_W'(N_REQ - 1);
            owner_q  <= '0;
            grant_q  <= '0;
            cause_q  <= DONE;
            enable_q <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    if (cnt == CNT_W'(INIT_CYCLES)) begin
                        state <= S_WARM;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_WARM: begin
                    if (cnt == CNT_W'(WARM_CYCLES - 1)) begin
                        state    <= S_IDLE;
                        cnt      <= '0;
                        enable_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_IDLE: begin
                    if (arb_valid) begin
                        state   <= S_LAUNCH;
                        grant_q <= arb_grant;
                        ptr     <= arb_idx;
                        owner_q <= arb_idx;
                    end
                end
                S_LAUNCH: begin
                    wd_cnt <= '0;
                    state  <= S_BUSY;
                end
                S_BUSY: begin
                    if (eng_err) begin
                        cause_q <= ENG_ERR;
                        state   <= S_FINISH;
                    end else if (wd_expire) begin
                        cause_q <= TIMEOUT_ERR;
                        state   <= S_FINISH;
                    end else if (stop_req) begin
                        cause_q <= STOPPED;
                        state   <= S_FINISH;
                    end else if (eng_done) begin
                        cause_q <= DONE;
                        state   <= S_FINISH;
                    end else if (TIMEOUT != 0) begin
                        wd_cnt <= wd_next[WD_W-1:0];
                    end
                end
                S_FINISH: state <= S_STATUS;
                S_STATUS: state <= S_IDLE;
                default:  state <= S_INIT;
            endcase
        end
    end

    assign rt           = (state == S_INIT);
    assign enable       = enable_q;
    assign start        = (state == S_LAUNCH);
    assign ack          = start ? grant_q : {N_REQ{1'b0}};
    assign rdy          = (state == S_FINISH);
    assign endd         = rdy && (cause_q == DONE);
    assign stop         = rdy && (cause_q == STOPPED);
    assign er           = rdy && ((cause_q == ENG_ERR) || (cause_q == TIMEOUT_ERR));
    assign interrupt    = rdy && (cause_q != DONE);
    assign status_valid = (state == S_STATUS);
    assign status       = cause_q;
    assign owner        = owner_q;

endmodule

// File: tb/tb_txn_sequencer.sv
// Randomised bench for txn_sequencer; expectations come from a timestamp-level model
// (grant cycle, response cycle, report cycles) rather than a state-by-state copy.
module tb_txn_sequencer;

    localparam int N_REQ       = 4;
    localparam int INIT_CYCLES = 4;
    localparam int TIMEOUT     = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] ack;
    logic             stop_req;
    logic             eng_done;
    logic             eng_err;
    logic             rt, enable, start, rdy, endd, stop, er, interrupt, status_valid;
    logic [1:0]       status;
    logic [1:0]       owner;

    int checks = 0;
    int errors = 0;
    int cyc;

    bit active;
    int idle_from;
    int launch_cyc;
    int resp_cyc;
    int winner;
    int model_ptr;
    int code;
    bit plan_done, plan_stop, plan_err;
    logic [N_REQ-1:0] grant_log[$];

    txn_sequencer #(
        .N_REQ      (N_REQ),
        .INIT_CYCLES(INIT_CYCLES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .ack         (ack),
        .stop_req    (stop_req),
        .eng_done    (eng_done),
        .eng_err     (eng_err),
        .rt          (rt),
        .enable      (enable),
        .start       (start),
        .rdy         (rdy),
        .endd        (endd),
        .stop        (stop),
        .er          (er),
        .interrupt   (interrupt),
        .status_valid(status_valid),
        .status      (status),
        .owner       (owner)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic modelReset();
        active     = 1'b0;
        idle_from  = INIT_CYCLES + 3;
        launch_cyc = -100;
        resp_cyc   = -100;
        model_ptr  = N_REQ - 1;
        winner     = 0;
        code       = 0;
        cyc        = -1;
    endtask

    // kind: 0 done, 1 done+stop, 2 err+stop, 3 silent engine, negative = random
    task automatic planResponse(input int kind);
        int d;
        int k;
        k = (kind < 0) ? int'($urandom_range(4, 0)) : kind;
        plan_done = 1'b0;
        plan_stop = 1'b0;
        plan_err  = 1'b0;
        d = 1;
        case (k)
            0: plan_done = 1'b1;
            1: begin plan_done = 1'b1; plan_stop = 1'b1; end
            2: begin plan_err = 1'b1; plan_stop = 1'b1; end
            3: d = TIMEOUT;
            default: begin
                plan_done = 1'($urandom % 2);
                plan_stop = 1'($urandom % 2);
                plan_err  = 1'($urandom % 2);
                if (!plan_done && !plan_stop && !plan_err) plan_done = 1'b1;
            end
        endcase
        if (kind < 0 && k != 3) d = int'($urandom_range(TIMEOUT, 1));
        if (plan_err)          code = 2;
        else if (d == TIMEOUT) code = 3;
        else if (plan_stop)    code = 1;
        else                   code = 0;
        resp_cyc = launch_cyc + d;
    endtask

    // mode 0: all requesters held high; mode 1: random requesters plus engine noise
    task automatic applyStimulus(input int ncycles, input int mode, input int kind, input bit until_busy);
        bit reached;
        bit found;
        bit exp_start, exp_rdy, exp_sv;
        logic [8:0] ctl_got, ctl_exp;
        logic [N_REQ-1:0] exp_ack;
        logic [N_REQ-1:0] bitm;
        int idx;
        reached = 1'b0;
        for (int n = 0; n < ncycles && !reached; n++) begin
            @(posedge clk);
            #1;
            cyc++;
            exp_start = active && (cyc == launch_cyc);
            exp_rdy   = active && (cyc == resp_cyc + 1);
            exp_sv    = active && (cyc == resp_cyc + 2);
            ctl_got = {rt, enable, start, rdy, endd, stop, er, interrupt, status_valid};
            ctl_exp = {cyc < INIT_CYCLES, cyc >= INIT_CYCLES + 3, exp_start, exp_rdy,
                       exp_rdy && code == 0, exp_rdy && code == 1, exp_rdy && code >= 2,
                       exp_rdy && code != 0, exp_sv};
            checkOutput("ctl", 32'(ctl_got), 32'(ctl_exp));
            exp_ack = exp_start ? (N_REQ'(1) << winner) : '0;
            checkOutput("ack", 32'(ack), 32'(exp_ack));
            if (ack != '0) grant_log.push_back(ack);
            if (exp_sv) begin
                checkOutput("status", 32'(status), 32'(code));
                checkOutput("owner", 32'(owner), 32'(winner));
                active    = 1'b0;
                idle_from = cyc + 1;
            end

            if (mode == 0) begin
                req = '1;
            end else begin
                if (exp_start) req = req & ~(N_REQ'(1) << winner);
                for (int i = 0; i < N_REQ; i++) begin
                    bitm = N_REQ'(1) << i;
                    if ((req & bitm) == '0) begin
                        if ($urandom % 4 == 0) req = req | bitm;
                    end else if ($urandom % 16 == 0) begin
                        req = req & ~bitm;
                    end
                end
            end

            stop_req = 1'b0;
            eng_done = 1'b0;
            eng_err  = 1'b0;
            if (active && cyc > launch_cyc && cyc <= resp_cyc) begin
                if (cyc == resp_cyc) begin
                    eng_done = plan_done;
                    stop_req = plan_stop;
                    eng_err  = plan_err;
                end
            end else if (mode == 1) begin
                eng_done = ($urandom % 3 == 0);
                stop_req = ($urandom % 3 == 0);
                eng_err  = ($urandom % 3 == 0);
            end

            if (!active && cyc >= idle_from && req != '0) begin
                found = 1'b0;
                for (int s = 1; s <= N_REQ; s++) begin
                    idx = (model_ptr + s) % N_REQ;
                    if (!found && (req & (N_REQ'(1) << idx)) != '0) begin
                        found  = 1'b1;
                        winner = idx;
                    end
                end
                active     = 1'b1;
                launch_cyc = cyc + 1;
                model_ptr  = winner;
                planResponse(kind);
            end

            if (until_busy && active && cyc > launch_cyc && cyc < resp_cyc) reached = 1'b1;
        end
        if (until_busy) checkOutput("busy_reached", 32'(reached), 32'(1));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout cycle=%0d got=running expected=finished", cyc);
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        rst      = 1'b0;
        req      = '0;
        stop_req = 1'b0;
        eng_done = 1'b0;
        eng_err  = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ctl", 32'({rt, enable, start, rdy, endd, stop, er, interrupt, status_valid}),
                    32'(9'b1_0000_0000));
        checkOutput("reset_ack", 32'(ack), 32'(0));
        checkOutput("reset_status", 32'(status), 32'(0));
        checkOutput("reset_owner", 32'(owner), 32'(0));

        req = '1;
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(33, 0, 0, 1'b0);
        checkOutput("grant_count", 32'(grant_log.size() >= 5), 32'(1));
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            checkOutput("grant_order", 32'(grant_log[i]), 32'(1 << (i % N_REQ)));

        applyStimulus(12, 0, 1, 1'b0);
        applyStimulus(20, 0, 3, 1'b0);
        applyStimulus(12, 0, 2, 1'b0);
        applyStimulus(600, 1, -1, 1'b0);
        applyStimulus(40, 0, 3, 1'b1);

        #2;
        rst      = 1'b0;
        stop_req = 1'b0;
        eng_done = 1'b0;
        eng_err  = 1'b0;
        #1;
        checkOutput("arst_ctl", 32'({rt, enable, start, rdy, endd, stop, er, interrupt, status_valid}),
                    32'(9'b1_0000_0000));
        checkOutput("arst_ack", 32'(ack), 32'(0));
        checkOutput("arst_status", 32'(status), 32'(0));
        checkOutput("arst_owner", 32'(owner), 32'(0));
        repeat (2) @(posedge clk);
        modelReset();
        req = '1;
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(30, 0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
